// File: rtl/enc_binder_pack_tm.sv
// Time-multiplexed binder pack: rotates NUM_CH level HVs by per-channel shifts
// using LANES shared rotators over ceil(NUM_CH/LANES) cycles.
module enc_binder_pack_tm #(
  parameter int unsigned HV_DIM       = 1024,
  parameter int unsigned NUM_CH       = 59,
  parameter int unsigned LANES        = 8,
  parameter int          BASE_SHIFT   = 0,
  parameter int          SHIFT_STRIDE = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              mode,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [HV_DIM-1:0] level_hv   [0:NUM_CH-1],
  output logic [HV_DIM-1:0] shifted_hv [0:NUM_CH-1],
  output logic              busy,
  output logic              done
);

  localparam int unsigned NUM_GRP = (NUM_CH + LANES - 1) / LANES;
  localparam int unsigned GW      = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
  localparam int unsigned SW      = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Wide arithmetic so large strides/channel counts never wrap before the modulo.
  function automatic int unsigned shift_of(input int unsigned c);
    longint v;
    v = (longint'(BASE_SHIFT) + longint'(c) * longint'(SHIFT_STRIDE)) % longint'(HV_DIM);
    if (v < 0) v = v + longint'(HV_DIM);
    return 32'(v);
  endfunction

  state_t            r_state, w_next;
  logic [GW-1:0]     r_grp;
  logic              r_mode;
  logic [NUM_CH-1:0] r_mask;
  logic              r_busy, r_done;
  logic [HV_DIM-1:0] r_shifted  [NUM_CH];
  logic [SW-1:0]     w_shift    [NUM_CH];
  logic [HV_DIM-1:0] w_lane_in  [LANES];
  logic [SW-1:0]     w_lane_sh  [LANES];
  logic [SW-1:0]     w_lane_eff [LANES];
  logic [HV_DIM-1:0] w_lane_out [LANES];
  logic              w_last;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_shift
    assign w_shift[c] = SW'(shift_of(c));
  end

  assign w_last = (r_grp == GW'(NUM_GRP - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Route the active group's channels onto the shared lanes, then rotate.
  // Bind (left by s) is done as a right rotate by HV_DIM-s on a doubled word.
  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      w_lane_in[l] = '0;
      w_lane_sh[l] = '0;
    end
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (r_grp == GW'(32'(c) / LANES)) begin
        w_lane_in[32'(c) % LANES] = level_hv[c];
        w_lane_sh[32'(c) % LANES] = w_shift[c];
      end
    end
    for (int l = 0; l < int'(LANES); l++) begin
      if (r_mode || (w_lane_sh[l] == '0)) w_lane_eff[l] = w_lane_sh[l];
      else                                 w_lane_eff[l] = SW'(HV_DIM - 32'(w_lane_sh[l]));
      w_lane_out[l] = HV_DIM'({w_lane_in[l], w_lane_in[l]} >> w_lane_eff[l]);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_grp  <= '0;
      r_mode <= 1'b0;
      r_mask <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      for (int c = 0; c < int'(NUM_CH); c++) r_shifted[c] <= '0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
      if (r_state == S_IDLE && start) begin
        r_mode <= mode;
        r_mask <= ch_mask;
        r_grp  <= '0;
      end else if (r_state == S_RUN) begin
        r_grp <= w_last ? '0 : r_grp + GW'(1);
        for (int c = 0; c < int'(NUM_CH); c++) begin
          if (r_grp == GW'(32'(c) / LANES))
            r_shifted[c] <= r_mask[c] ? w_lane_out[32'(c) % LANES] : '0;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign shifted_hv[c] = r_shifted[c];
  end

endmodule

// File: tb/tb_enc_binder_pack_tm.sv
// Bench for enc_binder_pack_tm: edge-count behavioural model checked every cycle,
// plus directed passes with hand-computed expectations.
module tb_enc_binder_pack_tm;

  localparam int unsigned HV = 16;
  localparam int unsigned NC = 5;
  localparam int unsigned LN = 2;
  localparam int unsigned NG = 3;
  localparam int          BS = 3;
  localparam int          SS = 2;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [NC-1:0] ch_mask = '0;
  logic [HV-1:0] level_hv   [NC];
  logic [HV-1:0] shifted_hv [NC];
  logic          busy, done;

  int n_vec = 0;
  int n_bad = 0;

  enc_binder_pack_tm #(.HV_DIM(HV), .NUM_CH(NC), .LANES(LN),
                       .BASE_SHIFT(BS), .SHIFT_STRIDE(SS)) dut (
    .clk(clk), .nrst(nrst), .start(start), .mode(mode), .ch_mask(ch_mask),
    .level_hv(level_hv), .shifted_hv(shifted_hv), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference rotation straight from the index formulas.
  function automatic logic [HV-1:0] rot(input logic [HV-1:0] v, input int s, input logic unb);
    logic [HV-1:0] o;
    for (int j = 0; j < int'(HV); j++)
      o[j] = unb ? v[(j + s) % int'(HV)] : v[(j - s + int'(HV)) % int'(HV)];
    return o;
  endfunction

  function automatic int shamt(input int c);
    return (BS + c * SS) % int'(HV);
  endfunction

  // Model: counts edges since an accepted start.
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  int            m_cnt = 0;
  logic          m_mode = 1'b0;
  logic [NC-1:0] m_mask = '0;
  logic [HV-1:0] m_exp [NC];

  initial for (int c = 0; c < int'(NC); c++) m_exp[c] = '0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_mode = 1'b0; m_mask = '0;
      for (int c = 0; c < int'(NC); c++) m_exp[c] = '0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1; m_cnt = 0; m_mode = mode; m_mask = ch_mask;
      end
    end else begin
      m_cnt++;
      for (int c = 0; c < int'(NC); c++)
        if (m_cnt == c / int'(LN) + 1)
          m_exp[c] = m_mask[c] ? rot(level_hv[c], shamt(c), m_mode) : '0;
      if (m_cnt == int'(NG)) m_done = 1'b1;
      else if (m_cnt == int'(NG) + 1) begin
        m_busy = 1'b0; m_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    for (int c = 0; c < int'(NC); c++)
      chk($sformatf("hv%0d", c), 32'(shifted_hv[c]), 32'(m_exp[c]));
  end

  task automatic run_pass(output int k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (k >= 30) chk("done_timeout", 32'(k), 32'(NG));
  endtask

  task automatic idle_gap();
    repeat (2) @(negedge clk);
  endtask

  task automatic set_all(input logic [HV-1:0] v);
    for (int c = 0; c < int'(NC); c++) level_hv[c] = v;
  endtask

  int k;
  int ndone;
  int dt [$];

  initial begin
    set_all('0);
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hv4", 32'(shifted_hv[4]), 32'h0);
    nrst = 1'b1;
    @(negedge clk);

    // Bind of a single-bit vector through shifts 3,5,7,9,11.
    set_all(16'h0001); mode = 1'b0; ch_mask = 5'b11111;
    run_pass(k);
    chk("t1_latency", 32'(k), 32'd3);
    chk("t1_hv0", 32'(shifted_hv[0]), 32'h0008);
    chk("t1_hv1", 32'(shifted_hv[1]), 32'h0020);
    chk("t1_hv2", 32'(shifted_hv[2]), 32'h0080);
    chk("t1_hv3", 32'(shifted_hv[3]), 32'h0200);
    chk("t1_hv4", 32'(shifted_hv[4]), 32'h0800);
    idle_gap();

    // Unbind round trip.
    set_all('0); level_hv[0] = 16'h0008; level_hv[4] = 16'h0800; mode = 1'b1;
    run_pass(k);
    chk("t2_hv0", 32'(shifted_hv[0]), 32'h0001);
    chk("t2_hv4", 32'(shifted_hv[4]), 32'h0001);
    idle_gap();

    // Channel mask.
    set_all(16'hFFFF); mode = 1'b0; ch_mask = 5'b10110;
    run_pass(k);
    chk("t3_hv0", 32'(shifted_hv[0]), 32'h0000);
    chk("t3_hv1", 32'(shifted_hv[1]), 32'hFFFF);
    chk("t3_hv2", 32'(shifted_hv[2]), 32'hFFFF);
    chk("t3_hv3", 32'(shifted_hv[3]), 32'h0000);
    chk("t3_hv4", 32'(shifted_hv[4]), 32'hFFFF);
    idle_gap();

    // Wrap-around on the largest shift.
    set_all('0); level_hv[4] = 16'h8001; ch_mask = 5'b11111;
    run_pass(k);
    chk("t4_hv4", 32'(shifted_hv[4]), 32'h0C00);
    idle_gap();

    // Starts at edges 1 and 3 of a pass are ignored.
    start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("t5_done_edge", 32'(i), 32'd3);
      end
      start = (i == 0 || i == 2);
    end
    chk("t5_done_count", 32'(ndone), 32'd1);

    // Start held high: back-to-back passes.
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dt.push_back(i);
    end
    start = 1'b0;
    chk("t5_held_count", 32'(dt.size()), 32'd4);
    for (int i = 1; i < dt.size(); i++)
      chk("t5_held_period", 32'(dt[i] - dt[i-1]), 32'd5);
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t5_drain", 32'(busy), 32'd0);
    @(negedge clk);

    // Asynchronous reset mid-pass.
    set_all(16'h0001); mode = 1'b0; ch_mask = 5'b11111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    for (int c = 0; c < int'(NC); c++)
      chk($sformatf("t6_hv%0d", c), 32'(shifted_hv[c]), 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_no_resume", 32'(busy), 32'd0);
    chk("t6_hv0_after", 32'(shifted_hv[0]), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
